montgomery_param: RTL and testbench



---
 rtl/montgomery_param.sv | 159 +++++++++++++++
 tb/tb_montgomery_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_param.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod M for odd M.
// One iteration per clock, then a single conditional subtraction; an even modulus is flagged through err.
module montgomery_param #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [WIDTH+1:0] ZERO_C    = {(WIDTH+2){1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH+1:0] c_r;
  logic [CW-1:0]    cnt_r;
  logic             bad_m_r;
  logic [WIDTH-1:0] result_r;
  logic             done_r;
  logic             busy_r;
  logic             err_r;

  logic [WIDTH+1:0] add_b_s;
  logic [WIDTH+1:0] t1_s;
  logic [WIDTH+1:0] add_m_s;
  logic [WIDTH+1:0] t2_s;
  logic [WIDTH+1:0] c_next_s;
  logic             ge_s;
  logic [WIDTH-1:0] diff_s;

  // C stays below 2M, so C + B + M fits in WIDTH+2 bits and T is always even after the M add.
  assign add_b_s  = a_r[0] ? {2'b00, b_r} : ZERO_C;
  assign t1_s     = c_r + add_b_s;
  assign add_m_s  = t1_s[0] ? {2'b00, m_r} : ZERO_C;
  assign t2_s     = t1_s + add_m_s;
  assign c_next_s = t2_s >> 1'b1;

  // C - M is non-negative exactly when C >= M; only the low WIDTH bits of the difference are kept.
  assign ge_s   = (c_r >= {2'b00, m_r});
  assign diff_s = c_r[WIDTH-1:0] - m_r;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; an even modulus skips the iterations entirely.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (in_m[0]) begin
            state_s = LOOP;
          end else begin
            state_s = SUB;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOOP: begin
        if (cnt_r == LAST_ITER) begin
          state_s = SUB;
        end else begin
          state_s = LOOP;
        end
      end
      SUB:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand latches, accumulator, counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_r      <= ZERO_W;
      b_r      <= ZERO_W;
      m_r      <= ZERO_W;
      c_r      <= ZERO_C;
      cnt_r    <= CNT_ZERO;
      bad_m_r  <= 1'b0;
      result_r <= ZERO_W;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= in_a;
            b_r     <= in_b;
            m_r     <= in_m;
            c_r     <= ZERO_C;
            cnt_r   <= CNT_ZERO;
            bad_m_r <= ~in_m[0];
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        LOOP: begin
          c_r   <= c_next_s;
          a_r   <= a_r >> 1'b1;
          cnt_r <= cnt_r + CNT_ONE;
        end
        SUB: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          if (bad_m_r) begin
            result_r <= ZERO_W;
            err_r    <= 1'b1;
          end else if (ge_s) begin
            result_r <= diff_s;
          end else begin
            result_r <= c_r[WIDTH-1:0];
          end
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_r;
  assign done   = done_r;
  assign busy   = busy_r;
  assign err    = err_r;

endmodule

// File: tb/tb_montgomery_param.sv
// Directed bench for montgomery_param at WIDTH=8: vector table plus back-to-back,
// held-start, even-modulus and mid-operation reset sequences.
module tb_montgomery_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_m;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic         err;

  int n_vec = 0;
  int n_bad = 0;

  montgomery_param #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_m   (in_m),
    .result (result),
    .done   (done),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic [W-1:0] res;
    logic         e;
    int           lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input string what, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, what, act, exp);
    end
  endtask

  // Caller is at a negedge; start is raised now and sampled at the next posedge (cycle 0).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                        input string name, input logic [W-1:0] exp_res, input logic exp_e,
                        input int exp_lat);
    int c;
    int got;
    int busy_ok;
    start = 1'b1;
    in_a  = a;
    in_b  = b;
    in_m  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a  = ~a;
    in_b  = ~b;
    in_m  = 8'h55;
    c = 0;
    got = -1;
    busy_ok = 1;
    while (got < 0 && c < 40) begin
      @(negedge clk);
      c++;
      if (done) begin
        got = c;
        if (busy) busy_ok = 0;
      end else if (!busy) begin
        busy_ok = 0;
      end
    end
    check(name, "latency", got, exp_lat);
    check(name, "result", int'(result), int'(exp_res));
    check(name, "err", int'(err), int'(exp_e));
    check(name, "busy_profile", busy_ok, 1);
  endtask

  initial begin
    int got;
    int ndone;
    logic [W-1:0] held;

    vecs[0]  = '{a: 8'd5,   b: 8'd7,   m: 8'd13,  res: 8'd1,   e: 1'b0, lat: 10};
    vecs[1]  = '{a: 8'd12,  b: 8'd12,  m: 8'd13,  res: 8'd3,   e: 1'b0, lat: 10};
    vecs[2]  = '{a: 8'd0,   b: 8'd7,   m: 8'd13,  res: 8'd0,   e: 1'b0, lat: 10};
    vecs[3]  = '{a: 8'd254, b: 8'd254, m: 8'd255, res: 8'd1,   e: 1'b0, lat: 10};
    vecs[4]  = '{a: 8'd1,   b: 8'd1,   m: 8'd255, res: 8'd1,   e: 1'b0, lat: 10};
    vecs[5]  = '{a: 8'd1,   b: 8'd1,   m: 8'd13,  res: 8'd3,   e: 1'b0, lat: 10};
    vecs[6]  = '{a: 8'd2,   b: 8'd3,   m: 8'd251, res: 8'd202, e: 1'b0, lat: 10};
    vecs[7]  = '{a: 8'd250, b: 8'd250, m: 8'd251, res: 8'd201, e: 1'b0, lat: 10};
    vecs[8]  = '{a: 8'd0,   b: 8'd0,   m: 8'd1,   res: 8'd0,   e: 1'b0, lat: 10};
    vecs[9]  = '{a: 8'd2,   b: 8'd2,   m: 8'd3,   res: 8'd1,   e: 1'b0, lat: 10};
    vecs[10] = '{a: 8'd3,   b: 8'd4,   m: 8'd12,  res: 8'd0,   e: 1'b1, lat: 2};
    vecs[11] = '{a: 8'd5,   b: 8'd7,   m: 8'd13,  res: 8'd1,   e: 1'b0, lat: 10};

    resetn = 1'b0;
    start  = 1'b0;
    in_a   = 8'd0;
    in_b   = 8'd0;
    in_m   = 8'd0;
    #12;
    check("reset", "result", int'(result), 0);
    check("reset", "done", int'(done), 0);
    check("reset", "busy", int'(busy), 0);
    check("reset", "err", int'(err), 0);
    #5;
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, $sformatf("vec%0d", i),
             vecs[i].res, vecs[i].e, vecs[i].lat);
    end

    // Result and err hold after the done pulse.
    held = result;
    @(negedge clk);
    check("hold", "done", int'(done), 0);
    check("hold", "result", int'(result), 1);
    check("hold", "err", int'(err), 0);

    // Back-to-back: the second start is raised in the done cycle of the first.
    @(negedge clk);
    run_op(8'd12, 8'd12, 8'd13, "b2b_first", 8'd3, 1'b0, 10);
    run_op(8'd0, 8'd7, 8'd13, "b2b_second", 8'd0, 1'b0, 10);

    // Even modulus then valid op clears err.
    @(negedge clk);
    run_op(8'd9, 8'd9, 8'd12, "even_m", 8'd0, 1'b1, 2);
    @(negedge clk);
    run_op(8'd5, 8'd7, 8'd13, "after_even", 8'd1, 1'b0, 10);

    // Start held high with inputs churning during LOOP; in-flight op must be unaffected.
    @(negedge clk);
    start = 1'b1;
    in_a  = 8'd5;
    in_b  = 8'd7;
    in_m  = 8'd13;
    got = -1;
    for (int c = 1; c <= 40 && got < 0; c++) begin
      @(posedge clk);
      #1;
      in_a = 8'd3;
      in_b = 8'd9;
      in_m = 8'd12;
      @(negedge clk);
      if (done) got = c;
    end
    start = 1'b0;
    check("held_start", "latency", got, 10);
    check("held_start", "result", int'(result), 1);
    check("held_start", "err", int'(err), 0);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("held_start", "extra_done", ndone, 0);

    // Asynchronous reset in cycle 4 of an operation.
    @(negedge clk);
    start = 1'b1;
    in_a  = 8'd12;
    in_b  = 8'd12;
    in_m  = 8'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset", "busy", int'(busy), 1);
    check("pre_reset", "result", int'(result), 1);
    #1;
    resetn = 1'b0;
    #1;
    check("mid_reset", "result", int'(result), 0);
    check("mid_reset", "done", int'(done), 0);
    check("mid_reset", "busy", int'(busy), 0);
    check("mid_reset", "err", int'(err), 0);
    #1;
    resetn = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("post_reset", "activity", ndone, 0);
    @(negedge clk);
    run_op(8'd5, 8'd7, 8'd13, "after_reset", 8'd1, 1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
